// File: rtl/energy_feed_pkg.sv
// Shared types and default sizes for the energy monitor feed sequencer.
package energy_feed_pkg;

   localparam int DEF_NUM_ROWS = 256;
   localparam int DEF_ENERGY_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CONFIG = 3'd1,
      ST_SPIN   = 3'd2,
      ST_WEIGHT = 3'd3,
      ST_WAIT_E = 3'd4
   } feed_state_t;

endpackage

// File: rtl/energy_feed_ctrl_watchdog.sv
// Timeout counter for the energy wait phase; fires on the cycle the limit is reached.
module feed_watchdog #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic active_i,
   output logic timeout_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   // Leaving the wait phase clears the count, so every entry starts from zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (!active_i) begin
         cnt <= '0;
      end else if (en_i) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign timeout_o = active_i & en_i & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/energy_feed_ctrl.sv
// Config/spin/weight beat sequencer and energy capture for the energy monitor.
// Optional watchdog with sticky error_o is enabled by defining ENERGY_FEED_TIMEOUT_EN.
module energy_feed_ctrl
   import energy_feed_pkg::*;
#(
   parameter int NUM_ROWS = DEF_NUM_ROWS,
   parameter int ENERGY_W = DEF_ENERGY_W,
`ifdef ENERGY_FEED_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 4096,
`endif
   localparam int ROW_W = $clog2(NUM_ROWS)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                flush_i,
   input  logic                start_i,
   input  logic                cfg_en_i,
   input  logic [ROW_W-1:0]    row_count_i,
   output logic                config_valid_o,
   input  logic                config_ready_i,
   output logic                spin_valid_o,
   input  logic                spin_ready_i,
   output logic                weight_valid_o,
   input  logic                weight_ready_i,
   output logic [ROW_W-1:0]    weight_addr_o,
   input  logic                energy_valid_i,
   output logic                energy_ready_o,
   input  logic [ENERGY_W-1:0] energy_i,
   output logic [ENERGY_W-1:0] energy_o,
   output logic                done_o,
`ifdef ENERGY_FEED_TIMEOUT_EN
   output logic                error_o,
`endif
   output logic                busy_o
);

   feed_state_t      state, state_next;
   logic [ROW_W-1:0] row_cnt;
   logic [ROW_W-1:0] last_row;
   logic             accept_start, config_hs, spin_hs, weight_hs, energy_hs;
   logic             timeout;

   assign accept_start = (state == ST_IDLE)   & start_i        & en_i & ~flush_i;
   assign config_hs    = (state == ST_CONFIG) & config_ready_i & en_i & ~flush_i;
   assign spin_hs      = (state == ST_SPIN)   & spin_ready_i   & en_i & ~flush_i;
   assign weight_hs    = (state == ST_WEIGHT) & weight_ready_i & en_i & ~flush_i;
   assign energy_hs    = (state == ST_WAIT_E) & energy_valid_i & en_i & ~flush_i & ~timeout;

`ifdef ENERGY_FEED_TIMEOUT_EN
   feed_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (en_i),
      .active_i (state == ST_WAIT_E),
      .timeout_o(timeout)
   );

   // Sticky until the host starts a fresh computation.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         error_o <= 1'b0;
      end else if (timeout) begin
         error_o <= 1'b1;
      end else if (accept_start) begin
         error_o <= 1'b0;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else if (en_i) begin
         state <= state_next;
      end
   end

   // Flush and watchdog expiry override every other transition.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (accept_start) state_next = cfg_en_i ? ST_CONFIG : ST_SPIN;
         ST_CONFIG: if (config_hs) state_next = ST_SPIN;
         ST_SPIN:   if (spin_hs) state_next = ST_WEIGHT;
         ST_WEIGHT: if (weight_hs && (row_cnt == last_row)) state_next = ST_WAIT_E;
         ST_WAIT_E: if (energy_hs) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
      if (flush_i || timeout) begin
         state_next = ST_IDLE;
      end
   end

   always_comb begin
      config_valid_o = 1'b0;
      spin_valid_o   = 1'b0;
      weight_valid_o = 1'b0;
      energy_ready_o = 1'b0;
      case (state)
         ST_CONFIG: config_valid_o = 1'b1;
         ST_SPIN:   spin_valid_o   = 1'b1;
         ST_WEIGHT: weight_valid_o = 1'b1;
         ST_WAIT_E: energy_ready_o = 1'b1;
         default:   ;
      endcase
   end

   assign busy_o        = (state != ST_IDLE);
   assign weight_addr_o = row_cnt;

   // The last row index is stored rather than the count: a count of 0 minus one
   // wraps to NUM_ROWS-1, which is exactly the full-array case for power-of-two sizes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         row_cnt  <= '0;
         last_row <= '0;
         energy_o <= '0;
         done_o   <= 1'b0;
      end else if (en_i) begin
         done_o <= energy_hs;
         if (accept_start) begin
            last_row <= row_count_i - ROW_W'(1);
         end
         if (spin_hs) begin
            row_cnt <= '0;
         end else if (weight_hs && (row_cnt != last_row)) begin
            row_cnt <= row_cnt + ROW_W'(1);
         end
         if (energy_hs) begin
            energy_o <= energy_i;
         end
      end
   end

endmodule

// File: tb/tb_energy_feed_ctrl.sv
// Directed self-checking bench for energy_feed_ctrl (watchdog case runs when ENERGY_FEED_TIMEOUT_EN is defined).
module tb_energy_feed_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        flush = 1'b0;
   logic        start = 1'b0;
   logic        cfg_en = 1'b0;
   logic [7:0]  row_count = 8'd0;
   logic        config_valid, config_ready = 1'b1;
   logic        spin_valid, spin_ready = 1'b1;
   logic        weight_valid, weight_ready = 1'b1;
   logic [7:0]  weight_addr;
   logic        energy_valid = 1'b0;
   logic        energy_ready;
   logic [31:0] energy_in = 32'd0;
   logic [31:0] energy_out;
   logic        done, busy;
`ifdef ENERGY_FEED_TIMEOUT_EN
   logic        error;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   energy_feed_ctrl #(
      .NUM_ROWS(256),
`ifdef ENERGY_FEED_TIMEOUT_EN
      .TIMEOUT_CYCLES(16),
`endif
      .ENERGY_W(32)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .en_i          (en),
      .flush_i       (flush),
      .start_i       (start),
      .cfg_en_i      (cfg_en),
      .row_count_i   (row_count),
      .config_valid_o(config_valid),
      .config_ready_i(config_ready),
      .spin_valid_o  (spin_valid),
      .spin_ready_i  (spin_ready),
      .weight_valid_o(weight_valid),
      .weight_ready_i(weight_ready),
      .weight_addr_o (weight_addr),
      .energy_valid_i(energy_valid),
      .energy_ready_o(energy_ready),
      .energy_i      (energy_in),
      .energy_o      (energy_out),
      .done_o        (done),
`ifdef ENERGY_FEED_TIMEOUT_EN
      .error_o       (error),
`endif
      .busy_o        (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int hs;
      int guard;
      logic seq_ok;
      logic [7:0] last_addr;

      // Reset state
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valids", {29'd0, config_valid, spin_valid, weight_valid}, 32'd0);
      check("rst_eready", 32'(energy_ready), 32'd0);
      check("rst_addr", 32'(weight_addr), 32'd0);
      check("rst_energy", energy_out, 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick();

      // Full sequence: cfg_en=1, 4 rows, all readies high
      energy_valid = 1'b1;
      energy_in = 32'h0000_1234;
      cfg_en = 1'b1;
      row_count = 8'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("seq_config_valid", 32'(config_valid), 32'd1);
      check("seq_busy", 32'(busy), 32'd1);
      tick();
      check("seq_spin_valid", 32'(spin_valid), 32'd1);
      check("seq_config_drop", 32'(config_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("seq_weight_valid", 32'(weight_valid), 32'd1);
         check("seq_weight_addr", 32'(weight_addr), 32'(i));
      end
      tick();
      check("seq_eready", 32'(energy_ready), 32'd1);
      check("seq_done_early", 32'(done), 32'd0);
      tick();
      check("seq_done", 32'(done), 32'd1);
      check("seq_energy", energy_out, 32'h0000_1234);
      check("seq_idle", 32'(busy), 32'd0);
      tick();
      check("seq_done_pulse", 32'(done), 32'd0);
      energy_valid = 1'b0;

      // Start ignored with en low; flush beats start in IDLE
      en = 1'b0;
      start = 1'b1;
      tick();
      check("en_low_start", 32'(busy), 32'd0);
      en = 1'b1;
      flush = 1'b1;
      tick();
      check("flush_start_idle", 32'(busy), 32'd0);
      flush = 1'b0;
      start = 1'b0;

      // Backpressure on weights, 3 rows, no config
      cfg_en = 1'b0;
      row_count = 8'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("bp_spin_valid", 32'(spin_valid), 32'd1);
      check("bp_no_config", 32'(config_valid), 32'd0);
      tick();
      check("bp_addr0", 32'(weight_addr), 32'd0);
      weight_ready = 1'b0;
      tick();
      check("bp_hold0_valid", 32'(weight_valid), 32'd1);
      check("bp_hold0_addr", 32'(weight_addr), 32'd0);
      weight_ready = 1'b1;
      tick();
      check("bp_addr1", 32'(weight_addr), 32'd1);
      en = 1'b0;
      tick();
      check("en_low_addr", 32'(weight_addr), 32'd1);
      check("en_low_valid", 32'(weight_valid), 32'd1);
      en = 1'b1;
      weight_ready = 1'b0;
      tick();
      check("bp_hold1_addr", 32'(weight_addr), 32'd1);
      weight_ready = 1'b1;
      tick();
      check("bp_addr2", 32'(weight_addr), 32'd2);
      weight_ready = 1'b0;
      tick();
      check("bp_hold2_valid", 32'(weight_valid), 32'd1);
      weight_ready = 1'b1;
      tick();
      check("bp_eready", 32'(energy_ready), 32'd1);
      check("bp_weight_drop", 32'(weight_valid), 32'd0);
      energy_valid = 1'b1;
      energy_in = 32'h0000_ABCD;
      tick();
      check("bp_done", 32'(done), 32'd1);
      check("bp_energy", energy_out, 32'h0000_ABCD);
      energy_valid = 1'b0;

      // row_count 0 means all 256 rows
      row_count = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("full_spin", 32'(spin_valid), 32'd1);
      tick();
      hs = 0;
      guard = 0;
      seq_ok = 1'b1;
      last_addr = 8'd0;
      while (weight_valid && guard < 400) begin
         if (weight_addr != 8'(hs)) seq_ok = 1'b0;
         last_addr = weight_addr;
         hs++;
         guard++;
         tick();
      end
      check("full_hs_count", 32'(hs), 32'd256);
      check("full_last_addr", 32'(last_addr), 32'd255);
      check("full_addr_seq", 32'(seq_ok), 32'd1);
      check("full_eready", 32'(energy_ready), 32'd1);
      energy_valid = 1'b1;
      energy_in = 32'h5555_0003;
      tick();
      check("full_energy", energy_out, 32'h5555_0003);
      energy_valid = 1'b0;

      // Flush during WEIGHT at row 2
      cfg_en = 1'b1;
      row_count = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      tick();
      check("fl_addr2", 32'(weight_addr), 32'd2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_idle", 32'(busy), 32'd0);
      check("fl_valids", {28'd0, config_valid, spin_valid, weight_valid, energy_ready}, 32'd0);
      check("fl_energy_kept", energy_out, 32'h5555_0003);
      check("fl_no_done", 32'(done), 32'd0);
      tick();
      check("fl_no_done_late", 32'(done), 32'd0);
      cfg_en = 1'b0;
      row_count = 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("fl_restart_addr", 32'(weight_addr), 32'd0);
      tick();
      tick();
      check("fl_restart_wait", 32'(energy_ready), 32'd1);

      // Async reset mid-WAIT_E, then spurious energy in IDLE
      rst = 1'b1;
      #2;
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_eready", 32'(energy_ready), 32'd0);
      check("ar_energy", energy_out, 32'd0);
      rst = 1'b0;
      energy_valid = 1'b1;
      energy_in = 32'h0000_DEAD;
      tick();
      tick();
      check("sp_energy", energy_out, 32'd0);
      check("sp_done", 32'(done), 32'd0);
      check("sp_busy", 32'(busy), 32'd0);
      energy_valid = 1'b0;

`ifdef ENERGY_FEED_TIMEOUT_EN
      // Watchdog: energy never arrives
      row_count = 8'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("wd_wait", 32'(energy_ready), 32'd1);
      for (int i = 0; i < 15; i++) tick();
      check("wd_still_wait", 32'(energy_ready), 32'd1);
      check("wd_no_err_yet", 32'(error), 32'd0);
      tick();
      check("wd_error", 32'(error), 32'd1);
      check("wd_idle", 32'(busy), 32'd0);
      check("wd_no_done", 32'(done), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("wd_err_clear", 32'(error), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
